// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: checks and aligns a control-word memory request, drives the
// data-cache port until it responds (or times out) and returns the extended load result.
module mem_access_unit #(
    parameter int unsigned MAX_WAIT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        done,
    output logic        err,
    output logic [31:0] dmem_address,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [3:0]  dmem_mbe,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp
);

    localparam int unsigned CntW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CntW-1:0] WaitLast = CntW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [31:0]     dmem_address_q, dmem_address_d;
    logic            dmem_read_q, dmem_read_d;
    logic            dmem_write_q, dmem_write_d;
    logic [3:0]      dmem_mbe_q, dmem_mbe_d;
    logic [31:0]     dmem_wdata_q, dmem_wdata_d;
    logic [2:0]      f3_q, f3_d;
    logic [1:0]      off_q, off_d;
    logic [CntW-1:0] wait_q, wait_d;
    logic [31:0]     load_q, load_d;
    logic            err_q, err_d;

    logic        req;
    logic        illegal;
    logic        timeout;
    logic [3:0]  store_mbe;
    logic [31:0] store_wdata;
    logic [15:0] lane;
    logic [31:0] load_ext;

    assign req     = mem_read | mem_write;
    assign timeout = (wait_q == WaitLast);

    // Anything the cache must never see: bad width, bad alignment, or both strobes at once.
    always_comb begin
        illegal = 1'b0;
        if (mem_read && mem_write) begin
            illegal = 1'b1;
        end else begin
            case (funct3)
                3'b000:  illegal = 1'b0;
                3'b001:  illegal = addr[0];
                3'b010:  illegal = |addr[1:0];
                3'b100:  illegal = mem_write;
                3'b101:  illegal = mem_write | addr[0];
                default: illegal = 1'b1;
            endcase
        end
    end

    always_comb begin
        case (funct3[1:0])
            2'b00:   store_mbe = 4'b0001 << addr[1:0];
            2'b01:   store_mbe = 4'b0011 << addr[1:0];
            default: store_mbe = 4'b1111;
        endcase
        store_wdata = funct3[1] ? store_data : (store_data << {addr[1:0], 3'b000});
    end

    // Low 16 bits of the read word shifted down to the accessed byte lane.
    always_comb begin
        case (off_q)
            2'd0:    lane = dmem_rdata[15:0];
            2'd1:    lane = dmem_rdata[23:8];
            2'd2:    lane = dmem_rdata[31:16];
            default: lane = {8'h00, dmem_rdata[31:24]};
        endcase
    end

    always_comb begin
        case (f3_q)
            3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b100:  load_ext = {24'h000000, lane[7:0]};
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b101:  load_ext = {16'h0000, lane[15:0]};
            default: load_ext = dmem_rdata;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = illegal ? StDone : StBusy;
                end
            end
            StBusy: begin
                if (dmem_resp || timeout) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs
    always_comb begin
        stall = 1'b0;
        done  = 1'b0;
        unique case (state_q)
            StIdle:  stall = req & ~illegal;
            StBusy:  stall = 1'b1;
            StDone:  done = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        dmem_address_d = dmem_address_q;
        dmem_read_d    = dmem_read_q;
        dmem_write_d   = dmem_write_q;
        dmem_mbe_d     = dmem_mbe_q;
        dmem_wdata_d   = dmem_wdata_q;
        f3_d           = f3_q;
        off_d          = off_q;
        wait_d         = wait_q;
        load_d         = load_q;
        err_d          = err_q;
        unique case (state_q)
            StIdle: begin
                if (req && illegal) begin
                    err_d  = 1'b1;
                    load_d = '0;
                end else if (req) begin
                    dmem_address_d = {addr[31:2], 2'b00};
                    dmem_read_d    = mem_read;
                    dmem_write_d   = mem_write;
                    dmem_mbe_d     = mem_write ? store_mbe : 4'b0000;
                    dmem_wdata_d   = mem_write ? store_wdata : '0;
                    f3_d           = funct3;
                    off_d          = addr[1:0];
                    wait_d         = '0;
                end
            end
            StBusy: begin
                if (dmem_resp) begin
                    dmem_read_d  = 1'b0;
                    dmem_write_d = 1'b0;
                    err_d        = 1'b0;
                    load_d       = dmem_read_q ? load_ext : '0;
                end else if (timeout) begin
                    dmem_read_d  = 1'b0;
                    dmem_write_d = 1'b0;
                    err_d        = 1'b1;
                    load_d       = '0;
                end else begin
                    wait_d = wait_q + CntW'(1);
                end
            end
            // err only qualifies the done pulse; clear it on the way back to idle.
            StDone:  err_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_address_q <= '0;
            dmem_read_q    <= 1'b0;
            dmem_write_q   <= 1'b0;
            dmem_mbe_q     <= '0;
            dmem_wdata_q   <= '0;
            f3_q           <= '0;
            off_q          <= '0;
            wait_q         <= '0;
            load_q         <= '0;
            err_q          <= 1'b0;
        end else begin
            dmem_address_q <= dmem_address_d;
            dmem_read_q    <= dmem_read_d;
            dmem_write_q   <= dmem_write_d;
            dmem_mbe_q     <= dmem_mbe_d;
            dmem_wdata_q   <= dmem_wdata_d;
            f3_q           <= f3_d;
            off_q          <= off_d;
            wait_q         <= wait_d;
            load_q         <= load_d;
            err_q          <= err_d;
        end
    end

    assign dmem_address = dmem_address_q;
    assign dmem_read    = dmem_read_q;
    assign dmem_write   = dmem_write_q;
    assign dmem_mbe     = dmem_mbe_q;
    assign dmem_wdata   = dmem_wdata_q;
    assign load_data    = load_q;
    assign err          = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a cache responder checks issued requests, a monitor
// checks completions, both against expectations pushed by the stimulus from a byte-level model.
module tb_mem_access_unit;

    localparam int MW = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] store_data = 32'd0;
    logic        stall;
    logic [31:0] load_data;
    logic        done;
    logic        err;
    logic [31:0] dmem_address;
    logic        dmem_read;
    logic        dmem_write;
    logic [3:0]  dmem_mbe;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata = 32'd0;
    logic        dmem_resp = 1'b0;

    mem_access_unit #(.MAX_WAIT(MW)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .funct3       (funct3),
        .addr         (addr),
        .store_data   (store_data),
        .stall        (stall),
        .load_data    (load_data),
        .done         (done),
        .err          (err),
        .dmem_address (dmem_address),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .dmem_mbe     (dmem_mbe),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [3:0]  mbe;
        logic [31:0] wdata;
        int          len;
    } req_t;

    typedef struct {
        logic        err;
        logic [31:0] load;
    } done_t;

    req_t        exp_req[$];
    done_t       exp_done[$];
    req_t        cur_req;
    int          resp_delay = 0;
    logic [31:0] cur_rdata = 32'd0;
    int          busy_cnt = 0;
    logic [31:0] last_load = 32'd0;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Cache model: checks each request against the scoreboard, holds it stable, responds
    // after the chosen number of busy cycles, and throws stray responses when idle.
    initial forever begin
        @(negedge clk);
        if (dmem_read || dmem_write) begin
            busy_cnt++;
            if (busy_cnt == 1) begin
                if (exp_req.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected strobe: got rd=%b wr=%b, required none", dmem_read,
                             dmem_write);
                    cur_req = '{addr: dmem_address, rd: dmem_read, wr: dmem_write,
                                mbe: dmem_mbe, wdata: dmem_wdata, len: MW};
                end else begin
                    cur_req = exp_req.pop_front();
                end
            end
            check("dmem_address", dmem_address, cur_req.addr);
            check("dmem_read", 32'(dmem_read), 32'(cur_req.rd));
            check("dmem_write", 32'(dmem_write), 32'(cur_req.wr));
            check("dmem_mbe", 32'(dmem_mbe), 32'(cur_req.mbe));
            check("dmem_wdata", dmem_wdata, cur_req.wdata);
            dmem_resp  = (resp_delay != 0) && (busy_cnt == resp_delay);
            dmem_rdata = dmem_resp ? cur_rdata : $urandom();
        end else begin
            if (busy_cnt != 0) check("busy length", busy_cnt, cur_req.len);
            busy_cnt   = 0;
            dmem_resp  = ($urandom_range(0, 3) == 0);
            dmem_rdata = $urandom();
        end
    end

    // Completion monitor.
    initial forever begin
        done_t dn;
        @(negedge clk);
        if (rst) begin
            last_load = 32'd0;
        end else if (done) begin
            if (exp_done.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected done: got done=1, required no pending access");
            end else begin
                dn = exp_done.pop_front();
                check("err", 32'(err), 32'(dn.err));
                check("load_data", load_data, dn.load);
                last_load = dn.load;
            end
        end else begin
            check("load_data hold", load_data, last_load);
        end
    end

    // Reference model plus driver for one instruction; entered and left just after a posedge.
    task automatic access(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, input logic [31:0] rdat, input int delay);
        int     sz, off, len, lat, k, st;
        bit     bad;
        longint v;
        req_t   rq;
        done_t  dn;
        sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
        off = int'(a % 4);
        bad = (rd && wr) || (sz == 0) ||
              (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) ||
              (wr && !(f3 inside {3'd0, 3'd1, 3'd2}));
        if (!bad && (off % sz) != 0) bad = 1'b1;
        len = (delay >= 1 && delay <= MW) ? delay : MW;
        if (bad) begin
            dn  = '{err: 1'b1, load: 32'd0};
            lat = 2;
        end else begin
            rq = '{addr: a & 32'hFFFF_FFFC, rd: rd, wr: wr, mbe: 4'd0, wdata: 32'd0, len: len};
            if (wr) begin
                for (int i = 0; i < sz; i++) rq.mbe[off+i] = 1'b1;
                rq.wdata = sd << (8 * off);
            end
            exp_req.push_back(rq);
            if (len != delay) begin
                dn = '{err: 1'b1, load: 32'd0};
            end else if (rd) begin
                v = longint'(rdat >> (8 * off)) % (longint'(1) << (8 * sz));
                if (!f3[2] && sz < 4 && v >= (longint'(1) << (8 * sz - 1)))
                    v = v - (longint'(1) << (8 * sz));
                dn = '{err: 1'b0, load: v[31:0]};
            end else begin
                dn = '{err: 1'b0, load: 32'd0};
            end
            lat = len + 2;
        end
        exp_done.push_back(dn);
        resp_delay = bad ? 0 : delay;
        cur_rdata  = rdat;
        mem_read   = rd;
        mem_write  = wr;
        funct3     = f3;
        addr       = a;
        store_data = sd;
        k  = 0;
        st = 0;
        do begin
            @(negedge clk);
            k++;
            if (stall) st++;
        end while (!done && k < 20);
        check("latency", k, lat);
        check("stall cycles", st, bad ? 0 : len + 1);
        @(posedge clk);
        #1;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        funct3     = 3'($urandom_range(0, 7));
        addr       = $urandom();
        store_data = $urandom();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset dmem_address", dmem_address, 32'd0);
        check("reset dmem_read", 32'(dmem_read), 32'd0);
        check("reset dmem_write", 32'(dmem_write), 32'd0);
        check("reset dmem_mbe", 32'(dmem_mbe), 32'd0);
        check("reset dmem_wdata", dmem_wdata, 32'd0);
        check("reset load_data", load_data, 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        access(1, 0, 3'b000, 32'h0000_1003, 32'd0, 32'h80FF_1234, 1);
        check("lb 0x1003", load_data, 32'hFFFF_FF80);
        access(0, 1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 32'd0, 4);
        access(1, 0, 3'b101, 32'h0000_3002, 32'd0, 32'h9ABC_0000, 2);
        check("lhu 0x3002", load_data, 32'h0000_9ABC);
        access(1, 0, 3'b001, 32'h0000_3002, 32'd0, 32'h9ABC_0000, 3);
        check("lh 0x3002", load_data, 32'hFFFF_9ABC);
        access(1, 0, 3'b010, 32'h0000_4001, 32'd0, 32'd0, 1);
        check("lw misaligned load_data", load_data, 32'd0);
        access(1, 1, 3'b010, 32'h0000_4000, 32'd0, 32'd0, 1);
        access(0, 1, 3'b010, 32'h0000_4800, 32'h1234_5678, 32'd0, 0);
        idle(3);

        // Reset during the second busy cycle of a load that never gets a response.
        exp_req.push_back('{addr: 32'h0000_6000, rd: 1'b1, wr: 1'b0, mbe: 4'd0, wdata: 32'd0,
                            len: 2});
        resp_delay = 0;
        mem_read   = 1'b1;
        funct3     = 3'b010;
        addr       = 32'h0000_6000;
        idle(2);
        rst = 1'b1;
        idle(1);
        rst      = 1'b0;
        mem_read = 1'b0;
        @(negedge clk);
        check("post-reset dmem_read", 32'(dmem_read), 32'd0);
        check("post-reset stall", 32'(stall), 32'd0);
        check("post-reset done", 32'(done), 32'd0);
        idle(4);
        access(0, 1, 3'b000, 32'h0000_5001, 32'h0000_00A5, 32'd0, 2);

        for (int i = 0; i < 160; i++) begin
            int          sel;
            logic [31:0] a;
            sel = $urandom_range(0, 9);
            a   = $urandom();
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            access(sel < 5 || sel == 9, sel >= 5, 3'($urandom_range(0, 7)), a, $urandom(),
                   $urandom(), $urandom_range(0, 5));
            idle($urandom_range(0, 2));
        end

        idle(4);
        check("pending requests", exp_req.size(), 32'd0);
        check("pending completions", exp_done.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Executes the memory half of the control word: consumes mem_read, mem_write and funct3 plus the ALU-computed address and rs2 data, and drives the data-cache port.
- Aligns byte enables and write data to the address, holds requests stable until dmem_resp, stalls the pipeline while busy, and returns sign- or zero-extended load data.
- Sits in the MEM stage, between the EX/MEM pipeline register and the data cache.

Parameters:
- MAX_WAIT, 256, cycles spent in BUSY without dmem_resp before the access is aborted with err; must be at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_read  in  1  control-word load request
- mem_write  in  1  control-word store request
- funct3  in  3  load/store width: 000 b, 001 h, 010 w, 100 bu, 101 hu
- addr  in  32  byte address (ALU output)
- store_data  in  32  rs2 value, unshifted
- stall  out  1  freeze upstream pipeline registers
- load_data  out  32  extended load result, valid when done=1
- done  out  1  one-cycle pulse when the access completes (success or err)
- err  out  1  qualifies done: misaligned, illegal funct3, read+write together, or timeout
- dmem_address  out  32  {addr[31:2],2'b00}
- dmem_read  out  1  cache read strobe
- dmem_write  out  1  cache write strobe
- dmem_mbe  out  4  byte enables
- dmem_wdata  out  32  lane-aligned write data
- dmem_rdata  in  32  cache read data
- dmem_resp  in  1  cache completion, one cycle

Behaviour:
- Clocking and reset: single clock, reset synchronous active-high.
- Reset values: state=IDLE, all dmem_* = 0, load_data = 0, done = 0, err = 0, wait counter = 0.
- States: IDLE, BUSY, DONE.
- Request definition: req = mem_read | mem_write.
- IDLE, legal request: stall=1 combinationally. Request fields are registered; next state is BUSY.
- IDLE, illegal request: stall stays 0. Next state is DONE with err=1 and load_data=0. No dmem strobe is issued. Illegal means any of:
  - lw/sw with addr[1:0]!=0
  - lh/lhu/sh with addr[0]=1
  - reserved funct3 (011, 110, 111; and 100/101 on a store)
  - mem_read=1 and mem_write=1 together
- BUSY:
  - dmem_read or dmem_write asserted from registered fields; all dmem_* held constant; stall=1.
  - On dmem_resp: capture data, go to DONE with err=0.
  - Wait counter increments each BUSY cycle without dmem_resp. When it reaches MAX_WAIT-1 with no response: drop strobes, go to DONE with err=1.
- DONE (exactly one cycle):
  - done=1, stall=0, dmem strobes 0; the pipeline advances at the end of this cycle.
  - Inputs are ignored, since the same instruction is still presented.
  - Next state is IDLE.
- Memory access latency: minimum 3 cycles from request to done (accept, BUSY with resp, DONE). An illegal request reaches done in 2 cycles.
- Byte enables, with off = addr[1:0]:
  - b: 4'b0001<<off
  - h: 4'b0011<<off
  - w: 4'b1111
  - dmem_mbe = 0 on reads.
- Write data: store_data << (8*off) for b/h; unshifted for w.
- Load extraction from the captured rdata, lane = rdata >> (8*off):
  - lb: sign-extend lane[7:0]
  - lbu: zero-extend lane[7:0]
  - lh: sign-extend lane[15:0]
  - lhu: zero-extend lane[15:0]
  - lw: rdata
  - load_data holds until the next done; it is 0 for stores and errors.
- dmem_resp outside BUSY is ignored.
- Reset mid-BUSY: the next edge returns to IDLE and strobes drop. A late response is then ignored.

Test Plan:
- lb, addr=0x1003, rdata=0x80FF_1234 -> dmem_address=0x1000, mbe=0, dmem_read=1 held until resp; load_data=0xFFFF_FF80, done=1, err=0; stall high exactly for accept+BUSY cycles.
- sh, addr=0x2002, store_data=0x0000_BEEF, resp after 4 BUSY cycles -> dmem_mbe=4'b1100, dmem_wdata=0xBEEF_0000, dmem_write stable all 4 cycles; done after resp.
- lhu at addr=0x3002 with rdata=0x9ABC_0000 -> load_data=0x0000_9ABC. lh at the same address -> load_data=0xFFFF_9ABC.
- lw, addr=0x4001 -> no dmem strobe, stall=0, next cycle done=1, err=1, load_data=0. mem_read=mem_write=1 -> same response.
- MAX_WAIT=4, sw with no dmem_resp -> dmem_write high 4 cycles then low; done=1, err=1. A dmem_resp injected afterwards is ignored.
- Reset asserted in 2nd BUSY cycle of an lw -> after that edge dmem_read=0, state IDLE, done never pulses; a following sb, addr=0x5001 -> mbe=4'b0010, completes normally.
